// File: rtl/xadc_aux_sequencer_if.sv
// ----------------------------------------------------------------------------
// xadc_aux_sequencer_if
//
// Bundles the XADC-facing signals used by xadc_aux_sequencer: the
// end-of-conversion pulse and the DRP read port.
//
//   eoc        XADC end-of-conversion, one-cycle pulse      (XADC -> seq)
//   drp_drdy   DRP read data valid                          (XADC -> seq)
//   drp_do     DRP read data, result in [15:4]              (XADC -> seq)
//   drp_den    DRP enable, one-cycle pulse                  (seq  -> XADC)
//   drp_dwe    DRP write enable, always 0                   (seq  -> XADC)
//   drp_daddr  DRP address                                  (seq  -> XADC)
//
// Modports:
//   master  the sequencer side (drives the DRP request)
//   slave   the XADC side (drives eoc and the read response)
// ----------------------------------------------------------------------------
interface xadc_aux_sequencer_if;
    logic        eoc;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;

    modport master (
        input  eoc, drp_drdy, drp_do,
        output drp_den, drp_dwe, drp_daddr
    );

    modport slave (
        output eoc, drp_drdy, drp_do,
        input  drp_den, drp_dwe, drp_daddr
    );
endinterface : xadc_aux_sequencer_if

// File: rtl/xadc_aux_sequencer.sv
// ----------------------------------------------------------------------------
// xadc_aux_sequencer
//
// Round-robin scheduler sharing the single XADC auxiliary input among four
// external analog channels. For each channel it drives the external mux,
// waits SETTLE_CYCLES clocks, waits for the next end-of-conversion, reads
// the DRP status register DRP_ADDR and stores the 12-bit result.
//
// Parameters:
//   SETTLE_CYCLES   clocks after a mux change before eoc is accepted (1..65535)
//   DRP_ADDR        DRP address read for every channel
//   TIMEOUT_CYCLES  drdy watchdog limit (only with XADC_SEQ_TIMEOUT_EN)
//
// Ports:
//   S_AXI_ACLK         clock for all logic
//   Local_Reset        asynchronous, active-high reset
//   enable             level; high runs the sequence continuously
//   onehot_mux         1 = one-hot mux select, 0 = binary
//   drp                XADC eoc + DRP port (master modport)
//   mux_sel            external analog mux select
//   MEASURED_AUX0..3   latest 12-bit result per channel
//   sample_valid       one-cycle strobe per channel on update
//   busy               high in every state except IDLE
//   timeout_err        sticky DRP timeout flag
//
// Build option:
//   XADC_SEQ_TIMEOUT_EN  when defined, a watchdog in DRP_WAIT abandons a read
//                        after TIMEOUT_CYCLES clocks without drdy, sets the
//                        sticky timeout_err and moves on to the next channel.
//                        When undefined, DRP_WAIT waits indefinitely and
//                        timeout_err is tied to 0.
// ----------------------------------------------------------------------------
module xadc_aux_sequencer #(
    parameter int         SETTLE_CYCLES  = 1000,
    parameter logic [6:0] DRP_ADDR       = 7'h13,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  Local_Reset,
    input  logic                  enable,
    input  logic                  onehot_mux,
    xadc_aux_sequencer_if.master  drp,
    output logic [3:0]            mux_sel,
    output logic [11:0]           MEASURED_AUX0,
    output logic [11:0]           MEASURED_AUX1,
    output logic [11:0]           MEASURED_AUX2,
    output logic [11:0]           MEASURED_AUX3,
    output logic [3:0]            sample_valid,
    output logic                  busy,
    output logic                  timeout_err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_settle
        $error("xadc_aux_sequencer: SETTLE_CYCLES must be 1..65535");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("xadc_aux_sequencer: TIMEOUT_CYCLES must be 1..65535");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETTLE   = 3'd1;
    localparam logic [2:0] ST_WAIT_EOC = 3'd2;
    localparam logic [2:0] ST_DRP_REQ  = 3'd3;
    localparam logic [2:0] ST_DRP_WAIT = 3'd4;
    localparam logic [2:0] ST_STORE    = 3'd5;

    // Terminal count: the counter starts at 0 on SETTLE entry, so leaving
    // when it reads SETTLE_CYCLES-1 puts WAIT_EOC exactly SETTLE_CYCLES
    // clocks after the entry edge.
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    // Mux select for a channel, in the encoding requested at SETTLE entry.
    function automatic logic [3:0] mux_encode(input logic [1:0] ch,
                                              input logic       onehot);
        return onehot ? (4'b0001 << ch) : {2'b00, ch};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  state_q,        state_d;
    logic [1:0]  ch_q,           ch_d;
    logic [3:0]  mux_sel_q,      mux_sel_d;
    logic [15:0] settle_cnt_q,   settle_cnt_d;
    logic        den_q,          den_d;
    logic [6:0]  daddr_q,        daddr_d;
    logic [11:0] meas_q [4];
    logic [11:0] meas_d [4];
    logic [3:0]  sample_valid_q, sample_valid_d;
    logic        busy_q,         busy_d;

`ifdef XADC_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tout_cnt_q,     tout_cnt_d;
    logic        timeout_err_q,  timeout_err_d;
`endif

    // Low nibble of the DRP status word is not part of the result.
    logic unused_drp_lsbs;
    assign unused_drp_lsbs = &{1'b0, drp.drp_do[3:0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // that no path leaves one unassigned; a missing default here would
        // infer a latch instead of combinational logic.
        state_d        = state_q;
        ch_d           = ch_q;
        mux_sel_d      = mux_sel_q;
        settle_cnt_d   = settle_cnt_q;
        den_d          = 1'b0;
        daddr_d        = '0;
        meas_d         = meas_q;
        sample_valid_d = '0;
`ifdef XADC_SEQ_TIMEOUT_EN
        tout_cnt_d     = tout_cnt_q;
        timeout_err_d  = timeout_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d      = ST_SETTLE;
                    mux_sel_d    = mux_encode(ch_q, onehot_mux);
                    settle_cnt_d = '0;
                end
            end

            // eoc is deliberately not looked at here: a conversion started
            // before the mux settled would carry the previous channel.
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_WAIT_EOC;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end

            // The request is registered on the transition so drp_den rises
            // on the edge after the accepted eoc and lasts one cycle.
            ST_WAIT_EOC: begin
                if (drp.eoc) begin
                    state_d = ST_DRP_REQ;
                    den_d   = 1'b1;
                    daddr_d = DRP_ADDR;
                end
            end

            ST_DRP_REQ: begin
                state_d = ST_DRP_WAIT;
`ifdef XADC_SEQ_TIMEOUT_EN
                tout_cnt_d = '0;
`endif
            end

            // Result and strobe are written on the drdy edge, so they are
            // visible during STORE. The pointer advances on the same edge;
            // STORE then loads the mux for the already-advanced channel.
            ST_DRP_WAIT: begin
                if (drp.drp_drdy) begin
                    meas_d[ch_q]         = drp.drp_do[15:4];
                    sample_valid_d[ch_q] = 1'b1;
                    ch_d                 = ch_q + 2'd1;
                    state_d              = ST_STORE;
                end
`ifdef XADC_SEQ_TIMEOUT_EN
                else if (tout_cnt_q == TIMEOUT_LAST) begin
                    // Abandon the read: keep the old value, no strobe.
                    timeout_err_d = 1'b1;
                    ch_d          = ch_q + 2'd1;
                    state_d       = ST_STORE;
                end else begin
                    tout_cnt_d = tout_cnt_q + 16'd1;
                end
`endif
            end

            ST_STORE: begin
                if (enable) begin
                    state_d      = ST_SETTLE;
                    mux_sel_d    = mux_encode(ch_q, onehot_mux);
                    settle_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered alongside the state so busy tracks it edge for edge.
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values; blocking assignments here would
    // make the result depend on statement order.
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            mux_sel_q      <= '0;
            settle_cnt_q   <= '0;
            den_q          <= 1'b0;
            daddr_q        <= '0;
            sample_valid_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            mux_sel_q      <= mux_sel_d;
            settle_cnt_q   <= settle_cnt_d;
            den_q          <= den_d;
            daddr_q        <= daddr_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
        end
    end

    // NOTE: the four result registers are reset because they are directly
    // visible as outputs and must read 0 after reset; a real RAM array
    // would normally be left unreset.
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            for (int i = 0; i < 4; i++) begin
                meas_q[i] <= '0;
            end
        end else begin
            meas_q <= meas_d;
        end
    end

`ifdef XADC_SEQ_TIMEOUT_EN
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            tout_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tout_cnt_q    <= tout_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign drp.drp_den   = den_q;
    assign drp.drp_dwe   = 1'b0;
    assign drp.drp_daddr = daddr_q;

    assign mux_sel       = mux_sel_q;
    assign MEASURED_AUX0 = meas_q[0];
    assign MEASURED_AUX1 = meas_q[1];
    assign MEASURED_AUX2 = meas_q[2];
    assign MEASURED_AUX3 = meas_q[3];
    assign sample_valid  = sample_valid_q;
    assign busy          = busy_q;

endmodule : xadc_aux_sequencer

// File: tb/tb_xadc_aux_sequencer.sv
// ----------------------------------------------------------------------------
// tb_xadc_aux_sequencer
//
// Self-checking bench for xadc_aux_sequencer with SETTLE_CYCLES=4 and
// TIMEOUT_CYCLES=8. The bench plays the XADC side (eoc, drdy, data) and
// keeps a per-channel model: the channel pointer, the expected result of
// each channel and the expected mux code, plus the cycle at which each
// event must appear. Inputs are driven and outputs sampled 1 ns after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_xadc_aux_sequencer;

    localparam int         SETTLE = 4;
    localparam int         TOUT   = 8;
    localparam logic [6:0] ADDR   = 7'h13;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        onehot_mux;
    logic [3:0]  mux_sel;
    logic [11:0] aux [4];
    logic [3:0]  sample_valid;
    logic        busy;
    logic        timeout_err;

    xadc_aux_sequencer_if drp_bus ();

    xadc_aux_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .DRP_ADDR       (ADDR),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .S_AXI_ACLK    (clk),
        .Local_Reset   (rst),
        .enable        (enable),
        .onehot_mux    (onehot_mux),
        .drp           (drp_bus),
        .mux_sel       (mux_sel),
        .MEASURED_AUX0 (aux[0]),
        .MEASURED_AUX1 (aux[1]),
        .MEASURED_AUX2 (aux[2]),
        .MEASURED_AUX3 (aux[3]),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    int          exp_ch;
    logic [11:0] exp_meas [4];
    bit          running;   // bench is positioned just after a SETTLE entry

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] mux_of(input int ch, input logic oh);
        return oh ? 4'(1 << ch) : 4'(ch);
    endfunction

    // Starts the sequence from IDLE if it is not already running.
    task automatic ensure_running();
        if (!running) begin
            repeat ($urandom_range(1, 4)) tick();
            enable = 1'b1;
            tick();
            running = 1'b1;
        end
    endtask

    // From SETTLE entry up to the first cycle of DRP_WAIT.
    task automatic run_to_drp_wait(input int eoc_wait, input bit early_eoc,
                                   input bit drop_en, input bit flip_oh);
        logic [3:0] exp_mux;
        exp_mux = mux_of(exp_ch, onehot_mux);
        checks++;
        if (mux_sel !== exp_mux) begin
            failures++;
            $display("FAIL mux_at_settle_entry ch=%0d got=%b exp=%b", exp_ch, mux_sel, exp_mux);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_settle got=%b exp=1", busy);
        end
        for (int c = 1; c <= SETTLE; c++) begin
            drp_bus.eoc = early_eoc && (c == 2);
            tick();
            checks++;
            if (drp_bus.drp_den !== 1'b0) begin
                failures++;
                $display("FAIL den_during_settle cycle=%0d got=%b exp=0", c, drp_bus.drp_den);
            end
        end
        drp_bus.eoc = 1'b0;
        if (drop_en) enable = 1'b0;
        if (flip_oh) onehot_mux = ~onehot_mux;
        for (int w = 0; w < eoc_wait; w++) begin
            drp_bus.drp_drdy = (w == 0);   // stray drdy, must be ignored
            tick();
            drp_bus.drp_drdy = 1'b0;
            checks++;
            if (drp_bus.drp_den !== 1'b0 || sample_valid !== 4'b0) begin
                failures++;
                $display("FAIL idle_in_wait_eoc w=%0d den=%b sv=%b exp den=0 sv=0", w, drp_bus.drp_den, sample_valid);
            end
        end
        drp_bus.eoc = 1'b1;
        tick();
        drp_bus.eoc = 1'b0;
        checks++;
        if (drp_bus.drp_den !== 1'b1 || drp_bus.drp_daddr !== ADDR || drp_bus.drp_dwe !== 1'b0) begin
            failures++;
            $display("FAIL drp_request den=%b addr=%h dwe=%b exp den=1 addr=%h dwe=0",
                     drp_bus.drp_den, drp_bus.drp_daddr, drp_bus.drp_dwe, ADDR);
        end
        checks++;
        if (mux_sel !== exp_mux) begin
            failures++;
            $display("FAIL mux_held ch=%0d got=%b exp=%b", exp_ch, mux_sel, exp_mux);
        end
        tick();
        checks++;
        if (drp_bus.drp_den !== 1'b0) begin
            failures++;
            $display("FAIL den_one_cycle got=%b exp=0", drp_bus.drp_den);
        end
    endtask

    // From the first DRP_WAIT cycle through STORE.
    task automatic finish_channel(input int drdy_lat, input logic [15:0] dout);
        logic [3:0] exp_sv;
        for (int w = 0; w < drdy_lat; w++) begin
            tick();
            checks++;
            if (sample_valid !== 4'b0) begin
                failures++;
                $display("FAIL early_sample_valid got=%b exp=0000", sample_valid);
            end
        end
        drp_bus.drp_do   = dout;
        drp_bus.drp_drdy = 1'b1;
        tick();
        drp_bus.drp_drdy = 1'b0;
        drp_bus.drp_do   = 16'($urandom);
        exp_meas[exp_ch] = dout[15:4];
        exp_sv           = 4'(1 << exp_ch);
        exp_ch           = (exp_ch + 1) % 4;
        checks++;
        if (sample_valid !== exp_sv) begin
            failures++;
            $display("FAIL sample_valid_pulse got=%b exp=%b", sample_valid, exp_sv);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aux[i] !== exp_meas[i]) begin
                failures++;
                $display("FAIL measured_aux%0d got=%h exp=%h", i, aux[i], exp_meas[i]);
            end
        end
        tick();
        checks++;
        if (sample_valid !== 4'b0) begin
            failures++;
            $display("FAIL sample_valid_one_cycle got=%b exp=0000", sample_valid);
        end
        checks++;
        if (busy !== enable) begin
            failures++;
            $display("FAIL busy_after_store got=%b exp=%b", busy, enable);
        end
        running = enable;
    endtask

    task automatic do_channel(input int eoc_wait, input int drdy_lat, input logic [15:0] dout,
                              input bit early_eoc, input bit drop_en, input bit flip_oh);
        ensure_running();
        run_to_drp_wait(eoc_wait, early_eoc, drop_en, flip_oh);
        finish_channel(drdy_lat, dout);
    endtask

    task automatic model_reset();
        exp_ch  = 0;
        running = 1'b0;
        for (int i = 0; i < 4; i++) exp_meas[i] = '0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (mux_sel !== 4'b0 || drp_bus.drp_den !== 1'b0 || drp_bus.drp_daddr !== 7'h0 ||
            sample_valid !== 4'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || drp_bus.drp_dwe !== 1'b0) begin
            failures++;
            $display("FAIL %s mux=%b den=%b addr=%h sv=%b busy=%b terr=%b dwe=%b exp all 0", tag,
                     mux_sel, drp_bus.drp_den, drp_bus.drp_daddr, sample_valid, busy, timeout_err, drp_bus.drp_dwe);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aux[i] !== 12'h0) begin
                failures++;
                $display("FAIL %s aux%0d got=%h exp=000", tag, i, aux[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;   // must not start while in reset
        repeat (3) tick();
        check_reset_values("reset_values");
        enable = 1'b0;
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_onehot_rotation();
        onehot_mux = 1'b1;
        for (int n = 0; n < 5; n++) begin
            do_channel($urandom_range(0, 3), $urandom_range(0, 4), 16'hABC0, 1'b0, 1'b0, n == 4);
        end
    endtask

    task automatic test_binary();
        for (int n = 0; n < 4; n++) begin
            do_channel($urandom_range(0, 3), $urandom_range(0, 4), 16'($urandom), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_early_eoc();
        do_channel(3, 1, 16'h5A50, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_enable_drop();
        while (exp_ch != 1) begin
            do_channel($urandom_range(0, 2), $urandom_range(0, 2), 16'($urandom), 1'b0, 1'b0, 1'b0);
        end
        do_channel(2, 2, 16'h1230, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drp_bus.eoc      = (k == 1);
            drp_bus.drp_drdy = (k == 3);
            tick();
            checks++;
            if (busy !== 1'b0 || sample_valid !== 4'b0 || drp_bus.drp_den !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_drop busy=%b sv=%b den=%b exp 0", busy, sample_valid, drp_bus.drp_den);
            end
        end
        drp_bus.eoc      = 1'b0;
        drp_bus.drp_drdy = 1'b0;
        // resumes at channel 2; the entry mux check covers it
        do_channel(1, 1, 16'h4560, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            do_channel($urandom_range(0, 4), $urandom_range(0, 5), 16'($urandom),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef XADC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        ensure_running();
        run_to_drp_wait($urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= TOUT; i++) begin
            tick();
            checks++;
            if (timeout_err !== (i == TOUT) || sample_valid !== 4'b0) begin
                failures++;
                $display("FAIL timeout_timing clk=%0d terr=%b sv=%b exp terr=%b sv=0000",
                         i, timeout_err, sample_valid, i == TOUT);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aux[i] !== exp_meas[i]) begin
                failures++;
                $display("FAIL timeout_value_kept aux%0d got=%h exp=%h", i, aux[i], exp_meas[i]);
            end
        end
        exp_ch = (exp_ch + 1) % 4;
        tick();
        running = 1'b1;
        do_channel(1, 1, 16'h7770, 1'b0, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
        end
    endtask
`else
    task automatic test_timeout();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_tied_low got=%b exp=0", timeout_err);
        end
    endtask
`endif

    task automatic test_reset_in_drp_wait();
        ensure_running();
        run_to_drp_wait(1, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check_reset_values("reset_async");
        model_reset();
        drp_bus.drp_do   = 16'hFFF0;
        drp_bus.drp_drdy = 1'b1;
        tick();
        drp_bus.drp_drdy = 1'b0;
        rst = 1'b0;
        tick();
        drp_bus.drp_drdy = 1'b1;
        tick();
        drp_bus.drp_drdy = 1'b0;
        tick();
        check_reset_values("late_drdy_ignored");
        // pointer restarts at channel 0
        do_channel(2, 3, 16'hC3C0, 1'b0, 1'b0, 1'b1);
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst              = 1'b1;
        enable           = 1'b0;
        onehot_mux       = 1'b1;
        drp_bus.eoc      = 1'b0;
        drp_bus.drp_drdy = 1'b0;
        drp_bus.drp_do   = '0;
        model_reset();

        test_reset();
        test_onehot_rotation();
        test_binary();
        test_early_eoc();
        test_enable_drop();
        test_random();
        test_timeout();
        test_reset_in_drp_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_xadc_aux_sequencer

// File: doc/xadc_aux_sequencer.md
# xadc_aux_sequencer

Round-robin scheduler that shares the single XADC auxiliary input among four external analog channels. It steps an external analog multiplexer, waits for the mux to settle and for a fresh conversion, reads the result over the XADC DRP port, and presents four registered 12-bit measurements. Its outputs feed the MEASURED_AUX0..3 inputs of the AXI configuration register block; `enable` and `onehot_mux` are driven from debug register bits.

## Interface

Parameters:
- SETTLE_CYCLES, 1000: clocks to wait after a mux change before a conversion is accepted; legal range 1..65535.
- DRP_ADDR, 7'h13: DRP status register address read for every channel.
- TIMEOUT_CYCLES, 255: DRP `drdy` watchdog limit; used only with XADC_SEQ_TIMEOUT_EN.

Ports:
- S_AXI_ACLK  in  1  single clock for all logic.
- Local_Reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; high runs the sequence continuously.
- onehot_mux  in  1  1 = one-hot mux select, 0 = binary.
- eoc  in  1  XADC end-of-conversion, one-cycle pulse.
- drp_drdy  in  1  DRP read data valid.
- drp_do  in  16  DRP read data; the result is in [15:4].
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  DRP write enable; constant 0.
- drp_daddr  out  7  DRP address.
- mux_sel  out  4  external analog mux select.
- MEASURED_AUX0..MEASURED_AUX3  out  12 each  latest result per channel.
- sample_valid  out  4  one-cycle strobe per channel on update.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky DRP timeout flag.

## Operation

- Reset values:
  - state IDLE, channel pointer 0
  - mux_sel 0, drp_den 0, drp_daddr 0
  - all MEASURED_AUXn 0, sample_valid 0, busy 0, timeout_err 0
- States:
  - IDLE: leave when `enable`=1 and go to SETTLE.
  - SETTLE: on entry, load `mux_sel` for the current channel and clear the settle counter. Count SETTLE_CYCLES clocks, then go to WAIT_EOC. An `eoc` during SETTLE is ignored.
  - WAIT_EOC: the first `eoc` goes to DRP_REQ. The state has no timeout.
  - DRP_REQ: assert `drp_den`=1 and `drp_daddr`=DRP_ADDR for exactly one cycle, then go to DRP_WAIT.
  - DRP_WAIT: on `drp_drdy`, capture `drp_do[15:4]` and go to STORE.
  - STORE: write MEASURED_AUX[ch] and pulse sample_valid[ch] for one cycle. Advance the channel as (ch+1) mod 4 (3 wraps to 0). Go to SETTLE if `enable`=1, otherwise IDLE.
- Mux encoding:
  - one-hot: 4'b0001 << ch
  - binary: {2'b00, ch[1:0]}
  - `onehot_mux` is sampled only on SETTLE entry; a change mid-channel takes effect on the next channel.
- Enable deasserted mid-channel: the current channel completes through STORE, then the block goes to IDLE. The channel pointer is retained, so re-enable resumes at the next channel.
- `drp_drdy` outside DRP_WAIT and `eoc` outside WAIT_EOC are ignored.
- Only STORE writes MEASURED_AUXn; values hold at all other times.
- Reset asserted in any state: immediate return to IDLE with the reset values above. Any in-flight DRP read is abandoned.

## Timing

- `mux_sel` changes on the clock edge that enters SETTLE.
- WAIT_EOC is entered exactly SETTLE_CYCLES clocks after SETTLE entry.
- `drp_den` rises on the edge after the accepted `eoc` and lasts exactly one cycle.
- MEASURED_AUXn and sample_valid[n] update on the edge after `drp_drdy`.
- Per-channel latency = 1 + SETTLE_CYCLES + eoc wait + 1 + drdy latency + 1 clocks.
- `busy` is registered with the state: it rises on the edge leaving IDLE and falls on the edge entering IDLE.

## Configuration

- Macro: XADC_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in DRP_WAIT.
  - If `drp_drdy` is absent for TIMEOUT_CYCLES clocks, set `timeout_err`=1.
  - Leave MEASURED_AUX[ch] unchanged and give no sample_valid pulse.
  - Advance the channel and continue as from STORE.
  - `timeout_err` clears only on reset.
- Undefined: DRP_WAIT waits indefinitely and `timeout_err` is tied to 0.

## Test plan

- Reset then enable=1, onehot_mux=1, SETTLE_CYCLES=4, with eoc and drdy (drp_do=16'hABC0) supplied per channel:
  - mux_sel runs 0001→0010→0100→1000→0001.
  - Each MEASURED_AUXn becomes 12'hABC.
  - Each sample_valid bit pulses once.
- onehot_mux=0: mux_sel runs 0000→0001→0010→0011.
- eoc pulsed in SETTLE cycle 2 and again 3 cycles after SETTLE ends: drp_den fires only after the second eoc.
- enable dropped during WAIT_EOC of channel 1:
  - channel 1 stores its result, then IDLE with busy=0
  - re-enable starts at channel 2
- Reset asserted in DRP_WAIT:
  - outputs return to reset values immediately
  - a later drdy is ignored
- With XADC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, no drdy:
  - timeout_err=1 after 8 clocks in DRP_WAIT
  - the channel value is unchanged and the pointer advances
